spi_slave_gen2: RTL
===================

// Module: spi_slave_gen2
// PURPOSE
//  Parametrised SPI slave front-end for the single-port RAM path, successor to the fixed 8-bit slave.
//  Deserialises MOSI frames of {cmd[1:0], payload[DATA_W-1:0]} into rx_data for the RAM controller.
//  On read-data frames it waits for tx_valid, then serialises tx_data on MISO.
//  Adds a timeout on tx_valid, detection of aborted frames, and tracking of the pending read address.
//  SPI is sampled on clk (SCK == clk); one clock domain.
// PARAMETERS
//  DATA_W      8   payload width; frame width FRAME_W = DATA_W+2
//  TX_TIMEOUT  16  max clk cycles from rx_valid (read data frame) to tx_valid; >=1
//  MISO_IDLE   0   MISO level whenever not shifting tx data
// PORTS
//  clk        in   1         system/SPI clock, all logic on rising edge
//  rst        in   1         reset, synchronous active-high
//  SS_n       in   1         slave select, active low
//  MOSI       in   1         serial data in, MSB first
//  MISO       out  1         serial data out, MSB first
//  rx_data    out  DATA_W+2  captured frame {cmd, payload}
//  rx_valid   out  1         1-cycle pulse, rx_data valid
//  tx_data    in   DATA_W    read data from RAM
//  tx_valid   in   1         tx_data valid; sampled only in WAIT_TX
//  frame_err  out  1         1-cycle pulse: frame aborted or TX timeout
//  busy       out  1         high whenever state != IDLE
// BEHAVIOUR
//  Reset (rst=1 at edge): state IDLE; MISO=MISO_IDLE, rx_data=0, rx_valid=0, frame_err=0,
//   read_sel=0, counters=0. rst has priority over all other events.
//  States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, DONE (encoding local).
//  IDLE: SS_n=0 -> CHK_CMD.
//  CHK_CMD: MOSI sampled into rx_data[FRAME_W-1]. MOSI=0 -> WRITE; MOSI=1 & !read_sel -> READ_ADD;
//   MOSI=1 & read_sel -> READ_DATA.
//  WRITE/READ_ADD/READ_DATA: shift the remaining FRAME_W-1 bits MSB first into rx_data,
//   one per clk. rx_data is stable from the last capture until the next frame.
//   rx_valid is asserted in the cycle after the last bit is captured.
//   Latency: rx_valid is high in the cycle after the (FRAME_W+1)th edge with SS_n low.
//   WRITE, READ_ADD -> DONE. READ_ADD completion sets read_sel=1.
//   READ_DATA -> WAIT_TX, with the timeout counter loaded to TX_TIMEOUT.
//  WAIT_TX: tx_valid=1 -> load tx_data into the shift register, then SEND. MISO shows MSB on the next cycle.
//   The counter reaching 0 without tx_valid -> frame_err pulse, read_sel=0, DONE.
//  SEND: DATA_W cycles MSB..LSB on MISO, then MISO=MISO_IDLE, read_sel=0, DONE.
//  DONE: MOSI ignored, no further rx_valid; SS_n=1 -> IDLE.
//  SS_n=1 in CHK_CMD..SEND (abort): IDLE next cycle, no rx_valid, frame_err pulse,
//   MISO=MISO_IDLE, read_sel unchanged, partial rx_data kept.
//  Simultaneous last-bit capture and SS_n rise: the frame counts as complete; rx_valid fires, no frame_err.
//  tx_valid outside WAIT_TX is ignored. rx_valid and frame_err are never high together.
// STRUCTURE
//  Package spi_pkg: state enum, command codes (WR_ADDR=00, WR_DATA=01, RD_ADDR=10, RD_DATA=11),
//   and the FRAME_W function.
//  Sub-module spi_shift_reg: parametrised width, serial-in/parallel-out plus parallel-load/serial-out,
//   with a bit counter and a done flag. Used once for RX and once for TX.
//  FSM, timeout counter and read_sel stay in the top module.
// TESTING (DATA_W=8)
//  Write frame 00_1010_0101 -> rx_data=10'h0A5, a single rx_valid pulse 11 edges after SS_n fell,
//   read_sel stays 0.
//  Read addr 10_0011_1100 then read data 11_xxxx_xxxx. tx_valid with tx_data=8'hC3 3 cycles after
//   rx_valid -> MISO 1,1,0,0,0,0,1,1, then read_sel=0.
//  Read data frame with no tx_valid -> frame_err exactly 16 cycles after rx_valid, MISO=0.
//  SS_n raised after 5 bits of a write -> IDLE, frame_err pulse, no rx_valid.
//   A new frame then decodes correctly.
//  rst=1 mid-SEND -> all outputs at reset values next cycle, read_sel=0.
//  SS_n rise in the same cycle as the last bit is captured -> rx_valid=1, frame_err=0.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared states, command codes and frame width helper for the SPI slave
package spi_pkg;
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, DONE} state_e;
  typedef enum logic [1:0] {WR_ADDR = 2'b00, WR_DATA = 2'b01, RD_ADDR = 2'b10, RD_DATA = 2'b11} cmd_e;
  function automatic int frame_w(input int data_w);
    return data_w + 2;
  endfunction
endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: MSB-first serial-in/parallel-out and parallel-load/serial-out register with bit counter
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         cap,
  input  logic         sin,
  input  logic         load,
  input  logic [W-1:0] pdata,
  input  logic         shift,
  output logic [W-1:0] q,
  output logic         sout,
  output logic         done
);
  localparam int CW = $clog2(W + 1);
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  assign idx = IW'(W - 1) - IW'(cnt);
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      cnt <= '0;
    end else if (load) begin
      q   <= pdata;
      cnt <= '0;
    end else if (cap) begin
      q[idx] <= sin;
      cnt    <= cnt + CW'(1);
    end else if (shift) begin
      q   <= q << 1;
      cnt <= cnt + CW'(1);
    end else if (clr) begin
      cnt <= '0;
    end
  end
  assign sout = q[W-1];
  assign done = cnt == CW'(W - 1);
endmodule

// File: rtl/spi_slave_gen2.sv
// spi_slave_gen2: parametrised SPI slave front-end with tx timeout, abort detection and read tracking
module spi_slave_gen2
  import spi_pkg::*;
#(
  parameter int   DATA_W     = 8,
  parameter int   TX_TIMEOUT = 16,
  parameter logic MISO_IDLE  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err,
  output logic              busy
);
  localparam int FRAME_W = frame_w(DATA_W);
  localparam int TW = $clog2(TX_TIMEOUT + 1);
  state_e state, state_n;
  logic [TW-1:0] tmo;
  logic read_sel, rx_state, rx_done, rx_cap, tx_load, tx_shift, tx_done, tx_sout;
  logic abort, tmo_hit, timeout, tx_fin, unused_rx_sout;
  logic [DATA_W-1:0] unused_tx_q;
  assign rx_state = state inside {WRITE, READ_ADD, READ_DATA};
  assign abort    = SS_n && state != IDLE && state != DONE && !(rx_state && rx_done);
  assign rx_cap   = (state == CHK_CMD || rx_state) && !abort;
  assign tmo_hit  = tmo == TW'(1);
  assign tx_load  = state == WAIT_TX && !SS_n && tx_valid;
  assign timeout  = state == WAIT_TX && !SS_n && !tx_valid && tmo_hit;
  assign tx_shift = state == SEND && !SS_n;
  assign tx_fin   = tx_shift && tx_done;
  assign busy     = state != IDLE;
  assign MISO     = (state == SEND) ? tx_sout : MISO_IDLE;
  spi_shift_reg #(.W(FRAME_W)) u_rx (
    .clk(clk), .rst(rst), .clr(state == IDLE), .cap(rx_cap), .sin(MOSI),
    .load(1'b0), .pdata('0), .shift(1'b0),
    .q(rx_data), .sout(unused_rx_sout), .done(rx_done)
  );
  spi_shift_reg #(.W(DATA_W)) u_tx (
    .clk(clk), .rst(rst), .clr(1'b0), .cap(1'b0), .sin(1'b0),
    .load(tx_load), .pdata(tx_data), .shift(tx_shift),
    .q(unused_tx_q), .sout(tx_sout), .done(tx_done)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:            state_n = SS_n ? IDLE : CHK_CMD;
      CHK_CMD:         state_n = SS_n ? IDLE : !MOSI ? WRITE : read_sel ? READ_DATA : READ_ADD;
      WRITE, READ_ADD: state_n = rx_done ? DONE : SS_n ? IDLE : state;
      READ_DATA:       state_n = rx_done ? WAIT_TX : SS_n ? IDLE : READ_DATA;
      WAIT_TX:         state_n = SS_n ? IDLE : tx_valid ? SEND : tmo_hit ? DONE : WAIT_TX;
      SEND:            state_n = SS_n ? IDLE : tx_done ? DONE : SEND;
      DONE:            state_n = SS_n ? IDLE : DONE;
      default:         state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tmo       <= '0;
      read_sel  <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      rx_valid  <= rx_state && rx_done;
      frame_err <= abort || timeout;
      tmo       <= (state == READ_DATA) ? TW'(TX_TIMEOUT) : (state == WAIT_TX) ? tmo - TW'(1) : tmo;
      read_sel  <= (state == READ_ADD && rx_done) || (read_sel && !(tx_fin || timeout));
    end
  end
endmodule
